// File: rtl/tsl_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tsl_scan_ctrl
//
// Time-shares one pulse-width detector among NUM_CH TSL235R light-to-frequency
// sensors. Each enabled channel is selected in turn. The detector is held in
// reset while the muxed input settles, and the first (incomplete) period is
// thrown away. 2^AVG_LOG2 full periods are then averaged and reported as a
// period / high-time pair for that channel. A channel that stops toggling is
// reported as a timeout instead of stalling the scan.
//
// Ports
//   ref_clk         clock, all logic on the rising edge
//   reset           synchronous, active-high
//   start           begin a scan (accepted only when idle)
//   continuous      sampled at end of scan: 1 = rescan with the same mask
//   ch_enable       channel mask, latched when start is accepted
//   sel_pulse       muxed sensor pulse (same net as the detector input)
//   det_hi_time     detector high-time register (cycles - 1)
//   det_lo_time     detector low-time register  (cycles - 1)
//   det_reset       detector reset
//   ch_sel          pulse mux select
//   busy            high whenever a scan is in progress
//   result_valid    one-cycle strobe qualifying the result_* ports
//   result_ch       channel of the current result
//   result_period   averaged period in ref_clk cycles (saturating)
//   result_hi       averaged high time in ref_clk cycles (saturating)
//   result_timeout  result is a dead-channel timeout, not a measurement
//   done            one-cycle strobe at the end of every scan
// -----------------------------------------------------------------------------
module tsl_scan_ctrl #(
    parameter int NUM_CH      = 4,
    parameter int SETTLE_CYC  = 16,
    parameter int AVG_LOG2    = 2,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                      ref_clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      continuous,
    input  logic [NUM_CH-1:0]         ch_enable,
    input  logic                      sel_pulse,
    input  logic [31:0]               det_hi_time,
    input  logic [31:0]               det_lo_time,
    output logic                      det_reset,
    output logic [$clog2(NUM_CH)-1:0] ch_sel,
    output logic                      busy,
    output logic                      result_valid,
    output logic [$clog2(NUM_CH)-1:0] result_ch,
    output logic [31:0]               result_period,
    output logic [31:0]               result_hi,
    output logic                      result_timeout,
    output logic                      done
);

    localparam int CH_W   = $clog2(NUM_CH);
    localparam int ACC_W  = 33 + AVG_LOG2;
    localparam int SCNT_W = AVG_LOG2 + 1;
    localparam int SET_W  = $clog2(SETTLE_CYC + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);

    localparam logic [SCNT_W-1:0] LAST_SAMPLE = SCNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [SET_W-1:0]  SETTLE_END  = SET_W'(SETTLE_CYC - 1);
    localparam logic [TO_W-1:0]   TIMEOUT_END = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_SETTLE,
        S_ARM,
        S_MEASURE,
        S_REPORT,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [NUM_CH-1:0] mask_q;      // mask latched at start, reused by continuous scans
    logic [NUM_CH-1:0] pending;     // channels not yet measured in this scan
    logic [CH_W-1:0]   next_ch;
    logic              pulse_q;
    logic              rise;
    logic              edge_d;      // a counted edge happened last cycle
    logic [SET_W-1:0]  settle_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [SCNT_W-1:0] samp_cnt;
    logic [ACC_W-1:0]  acc_period;
    logic [ACC_W-1:0]  acc_hi;
    logic [32:0]       sample_period;
    logic [32:0]       sample_hi;
    logic [ACC_W-1:0]  sum_period;
    logic [ACC_W-1:0]  sum_hi;
    logic              take_sample;
    logic              last_sample;
    logic              timeout_hit;

    // Average and clamp into 32 bits.
    function automatic logic [31:0] sat_avg(input logic [ACC_W-1:0] sum);
        logic [ACC_W-1:0] avg;
        avg = sum >> AVG_LOG2;
        return (|avg[ACC_W-1:32]) ? 32'hFFFF_FFFF : avg[31:0];
    endfunction

    // Lowest pending channel wins; scanning downwards leaves the lowest set bit.
    always_comb begin
        next_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pending[i]) next_ch = CH_W'(i);
        end
    end

    // The edge is seen in the same cycle the detector sees it: current pin
    // value against the one registered copy.
    assign rise = sel_pulse & ~pulse_q;

    // Detector registers count from zero, hence the +1 per phase.
    assign sample_hi     = {1'b0, det_hi_time} + 33'd1;
    assign sample_period = {1'b0, det_hi_time} + {1'b0, det_lo_time} + 33'd2;
    assign sum_period    = acc_period + ACC_W'(sample_period);
    assign sum_hi        = acc_hi + ACC_W'(sample_hi);

    assign take_sample = (state == S_MEASURE) && edge_d;
    assign last_sample = (samp_cnt == LAST_SAMPLE);
    assign timeout_hit = (to_cnt == TIMEOUT_END) && !rise;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of block ordering.
    always_ff @(posedge ref_clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // -------------------------------------------------------------------------
    // Next state and state-decoded outputs
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt    = state;
        det_reset    = 1'b1;
        busy         = 1'b1;
        result_valid = 1'b0;
        done         = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_SELECT;
            end
            S_SELECT:  state_nxt = (|pending) ? S_SETTLE : S_DONE;
            S_SETTLE: begin
                if (settle_cnt == SETTLE_END) state_nxt = S_ARM;
            end
            S_ARM: begin
                det_reset = 1'b0;
                if (rise)             state_nxt = S_MEASURE;
                else if (timeout_hit) state_nxt = S_REPORT;
            end
            S_MEASURE: begin
                det_reset = 1'b0;
                if (take_sample && last_sample) state_nxt = S_REPORT;
                else if (timeout_hit)           state_nxt = S_REPORT;
            end
            S_REPORT: begin
                result_valid = 1'b1;
                state_nxt    = (|pending) ? S_SELECT : S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = continuous ? S_SELECT : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: channel bookkeeping, counters, accumulators, result registers
    // -------------------------------------------------------------------------
    // NOTE: there is no RAM here, so every register is cleared by reset; that
    // is what guarantees partial sums from an aborted scan are discarded.
    always_ff @(posedge ref_clk) begin
        if (reset) begin
            mask_q         <= '0;
            pending        <= '0;
            ch_sel         <= '0;
            pulse_q        <= 1'b0;
            edge_d         <= 1'b0;
            settle_cnt     <= '0;
            to_cnt         <= '0;
            samp_cnt       <= '0;
            acc_period     <= '0;
            acc_hi         <= '0;
            result_ch      <= '0;
            result_period  <= '0;
            result_hi      <= '0;
            result_timeout <= 1'b0;
        end else begin
            pulse_q <= sel_pulse;
            // Only edges after the discarded one (i.e. seen in MEASURE) count.
            edge_d  <= (state == S_MEASURE) && rise;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        mask_q  <= ch_enable;
                        pending <= ch_enable;
                    end
                end
                S_SELECT: begin
                    settle_cnt <= '0;
                    if (|pending) begin
                        ch_sel  <= next_ch;
                        pending <= pending & ~(NUM_CH'(1) << next_ch);
                    end
                end
                S_SETTLE: begin
                    settle_cnt <= settle_cnt + SET_W'(1);
                    to_cnt     <= '0;
                end
                S_ARM, S_MEASURE: begin
                    to_cnt <= rise ? '0 : to_cnt + TO_W'(1);
                    if (take_sample) begin
                        acc_period <= sum_period;
                        acc_hi     <= sum_hi;
                        samp_cnt   <= samp_cnt + SCNT_W'(1);
                        // The final sample goes straight into the result so
                        // the strobe follows the capture by one cycle.
                        if (last_sample) begin
                            result_ch      <= ch_sel;
                            result_period  <= sat_avg(sum_period);
                            result_hi      <= sat_avg(sum_hi);
                            result_timeout <= 1'b0;
                        end
                    end else if (timeout_hit) begin
                        result_ch      <= ch_sel;
                        result_period  <= '0;
                        result_hi      <= '0;
                        result_timeout <= 1'b1;
                    end
                end
                S_REPORT: begin
                    acc_period <= '0;
                    acc_hi     <= '0;
                    samp_cnt   <= '0;
                end
                S_DONE: begin
                    if (continuous) pending <= mask_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tsl_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tsl_scan_ctrl
//
// Self-checking bench for tsl_scan_ctrl. A driver runs scans and plays a
// per-channel pulse train on sel_pulse, presenting detector readouts at each
// rising edge. For every channel it drives, it queues the expected report,
// computed from the channel's sample table with plain arithmetic. A monitor
// pops that queue on every result_valid strobe and compares.
// -----------------------------------------------------------------------------
module tb_tsl_scan_ctrl;

    localparam int NUM_CH      = 4;
    localparam int SETTLE_CYC  = 16;
    localparam int AVG_LOG2    = 2;
    localparam int TIMEOUT_CYC = 500;
    localparam int NS          = 1 << AVG_LOG2;

    logic              ref_clk = 1'b0;
    logic              reset;
    logic              start;
    logic              continuous;
    logic [NUM_CH-1:0] ch_enable;
    logic              sel_pulse;
    logic [31:0]       det_hi_time;
    logic [31:0]       det_lo_time;
    logic              det_reset;
    logic [1:0]        ch_sel;
    logic              busy;
    logic              result_valid;
    logic [1:0]        result_ch;
    logic [31:0]       result_period;
    logic [31:0]       result_hi;
    logic              result_timeout;
    logic              done;

    tsl_scan_ctrl #(
        .NUM_CH      (NUM_CH),
        .SETTLE_CYC  (SETTLE_CYC),
        .AVG_LOG2    (AVG_LOG2),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .ref_clk        (ref_clk),
        .reset          (reset),
        .start          (start),
        .continuous     (continuous),
        .ch_enable      (ch_enable),
        .sel_pulse      (sel_pulse),
        .det_hi_time    (det_hi_time),
        .det_lo_time    (det_lo_time),
        .det_reset      (det_reset),
        .ch_sel         (ch_sel),
        .busy           (busy),
        .result_valid   (result_valid),
        .result_ch      (result_ch),
        .result_period  (result_period),
        .result_hi      (result_hi),
        .result_timeout (result_timeout),
        .done           (done)
    );

    always #5 ref_clk = ~ref_clk;

    typedef struct {
        int     ch;
        longint period;
        longint hi;
        bit     tmo;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp     = 0;
    int   n_bad     = 0;
    int   done_seen = 0;
    int   done_exp  = 0;

    // Per-channel stimulus: waveform phase lengths and the detector readouts
    // presented at the rising edge that closes each counted period.
    bit          dead [NUM_CH];
    int unsigned hcyc [NUM_CH][NS];
    int unsigned lcyc [NUM_CH][NS];
    logic [31:0] dhi  [NUM_CH][NS];
    logic [31:0] dlo  [NUM_CH][NS];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    task automatic tick();
        @(posedge ref_clk);
        #1;
    endtask

    // Reference: average of the counted periods, clamped to 32 bits.
    function automatic exp_t model(input int ch);
        exp_t   e;
        longint sp;
        longint sh;
        sp    = 0;
        sh    = 0;
        e.ch  = ch;
        e.tmo = dead[ch];
        if (dead[ch]) begin
            e.period = 0;
            e.hi     = 0;
        end else begin
            for (int k = 0; k < NS; k++) begin
                sp += longint'(dhi[ch][k]) + longint'(dlo[ch][k]) + 2;
                sh += longint'(dhi[ch][k]) + 1;
            end
            e.period = sp / NS;
            e.hi     = sh / NS;
            if (e.period > 64'hFFFF_FFFF) e.period = 64'hFFFF_FFFF;
            if (e.hi > 64'hFFFF_FFFF)     e.hi     = 64'hFFFF_FFFF;
        end
        return e;
    endfunction

    task automatic set_wave(input int ch, input int k, input int unsigned h, input int unsigned l);
        hcyc[ch][k] = h;
        lcyc[ch][k] = l;
        dhi[ch][k]  = 32'(h - 1);
        dlo[ch][k]  = 32'(l - 1);
    endtask

    task automatic set_uniform(input int ch, input int unsigned h, input int unsigned l);
        dead[ch] = 1'b0;
        for (int k = 0; k < NS; k++) set_wave(ch, k, h, l);
    endtask

    task automatic set_random(input int ch);
        dead[ch] = ($urandom_range(7) == 0);
        for (int k = 0; k < NS; k++) set_wave(ch, k, $urandom_range(12, 1), $urandom_range(12, 1));
    endtask

    // Monitor: every result strobe must match the oldest queued expectation.
    always @(negedge ref_clk) begin : monitor
        exp_t e;
        if (result_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: ch %0d reported with nothing expected", result_ch);
            end else begin
                e = exp_q.pop_front();
                check("result_ch",      64'(result_ch),      64'(e.ch));
                check("result_period",  64'(result_period),  e.period);
                check("result_hi",      64'(result_hi),      e.hi);
                check("result_timeout", 64'(result_timeout), 64'(e.tmo));
            end
        end
        if (done) begin
            done_seen++;
            check("results_before_done", 64'(exp_q.size()), 64'd0);
        end
    end

    task automatic wait_det(input logic lvl, input string name, output int n);
        n = 0;
        while (det_reset !== lvl && n < 4000) begin
            tick();
            n++;
        end
        if (det_reset !== lvl) bound_fail(name);
    endtask

    // Play one measured channel: discarded edge, NS counted periods, then
    // check the strobe lands two cycles after the last counted edge.
    task automatic drive_ch(input int ch, input bit poke);
        int n;
        sel_pulse = 1'b0;
        tick();
        tick();
        sel_pulse = 1'b1;
        for (int k = 0; k < NS; k++) begin
            repeat (hcyc[ch][k]) tick();
            sel_pulse = 1'b0;
            if (poke && k == 1) begin
                start = 1'b1;
                tick();
                start = 1'b0;
                repeat (lcyc[ch][k] - 1) tick();
            end else begin
                repeat (lcyc[ch][k]) tick();
            end
            sel_pulse   = 1'b1;
            det_hi_time = dhi[ch][k];
            det_lo_time = dlo[ch][k];
        end
        n = 0;
        while (result_valid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check("report_latency", 64'(n), 64'd2);
        sel_pulse = 1'b0;
    endtask

    task automatic drive_dead(input int ch);
        int n;
        sel_pulse = 1'b0;
        n = 0;
        while (result_valid !== 1'b1 && n < 2 * TIMEOUT_CYC) begin
            tick();
            n++;
        end
        check("timeout_latency", 64'(n), 64'(TIMEOUT_CYC));
    endtask

    task automatic run_scan(input logic [NUM_CH-1:0] mask, input bit use_start,
                            input bit cont, input int poke_ch);
        int  n;
        bit  first;
        first      = 1'b1;
        continuous = cont;
        if (use_start) begin
            ch_enable = mask;
            start     = 1'b1;
            tick();
            start     = 1'b0;
            ch_enable = NUM_CH'($urandom);   // must not affect the running scan
            check("busy_after_start", 64'(busy), 64'd1);
        end
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (mask[ch]) begin
                wait_det(1'b1, "det_reset_rise", n);
                wait_det(1'b0, "det_reset_fall", n);
                if (first && use_start) check("settle_length", 64'(n), 64'(SETTLE_CYC + 1));
                first = 1'b0;
                check("ch_sel", 64'(ch_sel), 64'(ch));
                exp_q.push_back(model(ch));
                if (dead[ch]) drive_dead(ch);
                else          drive_ch(ch, poke_ch == ch);
            end
        end
        n = 0;
        while (done !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (done !== 1'b1) bound_fail("done_wait");
        else check("done_latency", 64'(n), 64'd1);
        done_exp++;
        tick();
        check("busy_after_done", 64'(busy), 64'(cont));
    endtask

    initial begin : watchdog
        #900_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int n;
        reset       = 1'b1;
        start       = 1'b0;
        continuous  = 1'b0;
        ch_enable   = '0;
        sel_pulse   = 1'b0;
        det_hi_time = '0;
        det_lo_time = '0;
        for (int ch = 0; ch < NUM_CH; ch++) set_uniform(ch, 4, 4);
        repeat (3) tick();

        check("rst_det_reset",      64'(det_reset),      64'd1);
        check("rst_ch_sel",         64'(ch_sel),         64'd0);
        check("rst_busy",           64'(busy),           64'd0);
        check("rst_result_valid",   64'(result_valid),   64'd0);
        check("rst_result_ch",      64'(result_ch),      64'd0);
        check("rst_result_period",  64'(result_period),  64'd0);
        check("rst_result_hi",      64'(result_hi),      64'd0);
        check("rst_result_timeout", 64'(result_timeout), 64'd0);
        check("rst_done",           64'(done),           64'd0);
        reset = 1'b0;
        tick();

        // Basic: one channel, high 10 / low 30.
        set_uniform(0, 10, 30);
        run_scan(4'b0001, 1'b1, 1'b0, -1);

        // Round robin, with a start pulse during ch1's measurement.
        set_uniform(1, 25, 75);
        set_uniform(3, 32, 32);
        run_scan(4'b1010, 1'b1, 1'b0, 1);

        // Dead channel.
        dead[2] = 1'b1;
        run_scan(4'b0100, 1'b1, 1'b0, -1);
        dead[2] = 1'b0;

        // Truncating average: 40, 41, 41, 41 -> 40.
        set_wave(0, 0, 10, 30);
        for (int k = 1; k < NS; k++) set_wave(0, k, 10, 31);
        run_scan(4'b0001, 1'b1, 1'b0, -1);

        // Saturation: huge detector readouts on a short real waveform.
        set_uniform(3, 3, 3);
        for (int k = 0; k < NS; k++) begin
            dhi[3][k] = 32'hFFFF_FFF0;
            dlo[3][k] = 32'h0000_0100;
        end
        run_scan(4'b1000, 1'b1, 1'b0, -1);

        // Empty mask: done two cycles after start, no result.
        run_scan(4'b0000, 1'b1, 1'b0, -1);

        // Continuous: second scan runs off the latched mask with no start.
        set_random(0);
        set_random(1);
        dead[0] = 1'b0;
        dead[1] = 1'b0;
        run_scan(4'b0011, 1'b1, 1'b1, -1);
        set_random(0);
        set_random(1);
        run_scan(4'b0011, 1'b0, 1'b0, -1);

        // Reset mid-measurement: no strobes, everything back to reset values.
        set_uniform(0, 5, 7);
        ch_enable = 4'b0001;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        wait_det(1'b1, "abort_det_rise", n);
        wait_det(1'b0, "abort_det_fall", n);
        sel_pulse = 1'b0;
        tick();
        tick();
        sel_pulse = 1'b1;
        repeat (5) tick();
        sel_pulse = 1'b0;
        repeat (7) tick();
        sel_pulse   = 1'b1;
        det_hi_time = 32'd4;
        det_lo_time = 32'd6;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("abort_det_reset",     64'(det_reset),     64'd1);
        check("abort_busy",          64'(busy),          64'd0);
        check("abort_result_valid",  64'(result_valid),  64'd0);
        check("abort_done",          64'(done),          64'd0);
        check("abort_result_period", 64'(result_period), 64'd0);
        reset     = 1'b0;
        sel_pulse = 1'b0;
        repeat (3) tick();
        set_uniform(0, 6, 9);
        run_scan(4'b0001, 1'b1, 1'b0, -1);

        // Random scans.
        for (int s = 0; s < 8; s++) begin
            for (int ch = 0; ch < NUM_CH; ch++) set_random(ch);
            run_scan(NUM_CH'($urandom_range(15, 1)), 1'b1, 1'b0, -1);
        end

        repeat (5) tick();
        check("pending_expectations", 64'(exp_q.size()), 64'd0);
        check("done_count", 64'(done_seen), 64'(done_exp));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
